axi_pattern_master: RTL and testbench

- Parametrised AXI4 master that replaces a tie-off master.
- When idle it holds every master-driven signal at its inactive value.
- On `start` it writes a deterministic incrementing pattern over a burst region, reads the region back, and checks the data and responses.
- It sits on any `axi_channel` slave port as a bring-up and interconnect self-test.

---
 rtl/axi_pattern_master_if.sv | 89 ++++++++
 rtl/axi_pattern_master.sv | 200 ++++++++++++++++++++
 tb/tb_axi_pattern_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pattern_master_if.sv
// AXI4 channel bundle shared by masters and slaves; ID fields only on the request side.
interface axi_channel #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Write address channel
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_lock;
    logic [3:0]            aw_cache;
    logic [2:0]            aw_prot;
    logic [3:0]            aw_qos;
    logic [3:0]            aw_region;
    logic [USER_WIDTH-1:0] aw_user;
    logic                  aw_valid;
    logic                  aw_ready;

    // Write data channel
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_last;
    logic [USER_WIDTH-1:0] w_user;
    logic                  w_valid;
    logic                  w_ready;

    // Write response channel
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;

    // Read address channel
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_lock;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;
    logic [3:0]            ar_region;
    logic [USER_WIDTH-1:0] ar_user;
    logic                  ar_valid;
    logic                  ar_ready;

    // Read data channel
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_pattern_master.sv
// AXI4 self-test master: writes SEED+k over NUM_BURSTS INCR bursts, reads them back, counts errors.
module axi_pattern_master #(
    parameter int unsigned            ADDR_WIDTH = 64,
    parameter int unsigned            DATA_WIDTH = 64,
    parameter int unsigned            ID_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int unsigned            BURST_LEN  = 4,
    parameter int unsigned            NUM_BURSTS = 8,
    parameter logic [31:0]            SEED       = 32'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] error_count,
    axi_channel.master  master
);
    localparam int unsigned BYTES   = DATA_WIDTH / 8;
    localparam int unsigned SIZE    = $clog2(BYTES);
    localparam int unsigned STRIDE  = BURST_LEN * BYTES;
    localparam int unsigned BEAT_W  = (BURST_LEN > 1)  ? $clog2(BURST_LEN)  : 1;
    localparam int unsigned BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q;
    logic [BURST_W-1:0]      burst_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   pat_q;
    logic [15:0]             err_q;

    logic aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q, busy_q, done_q;
    logic aw_valid_d, w_valid_d, b_ready_d, ar_valid_d, r_ready_d, busy_d, done_d;

    logic last_beat, last_burst, b_err, r_err, err_inc;

    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);
    assign b_err      = (master.b_resp != 2'b00);
    assign r_err      = (master.r_data != pat_q) || (master.r_resp != 2'b00)
                        || (master.r_last != last_beat);
    assign err_inc    = ((state_q == S_B) && master.b_valid && b_err)
                        || ((state_q == S_R) && master.r_valid && r_err);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic, one outstanding transaction at a time
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start)                        state_d = S_AW;
            S_AW:   if (master.aw_ready)              state_d = S_W;
            S_W:    if (master.w_ready && last_beat)  state_d = S_B;
            S_B:    if (master.b_valid)               state_d = last_burst ? S_AR : S_AW;
            S_AR:   if (master.ar_ready)              state_d = S_R;
            S_R:    if (master.r_valid && last_beat)  state_d = last_burst ? S_DONE : S_AR;
            S_DONE:                                   state_d = S_IDLE;
            default:                                  state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        b_ready_d  = 1'b0;
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        case (state_d)
            S_AW:    aw_valid_d = 1'b1;
            S_W:     w_valid_d  = 1'b1;
            S_B:     b_ready_d  = 1'b1;
            S_AR:    ar_valid_d = 1'b1;
            S_R:     r_ready_d  = 1'b1;
            S_DONE:  done_d     = 1'b1;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Beat/burst counters, running address and pattern, saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= '0;
            burst_q <= '0;
            addr_q  <= BASE_ADDR;
            pat_q   <= DATA_WIDTH'(SEED);
            err_q   <= '0;
        end else begin
            if (err_inc && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
            case (state_q)
                S_IDLE: if (start) begin
                    beat_q  <= '0;
                    burst_q <= '0;
                    addr_q  <= BASE_ADDR;
                    pat_q   <= DATA_WIDTH'(SEED);
                    err_q   <= '0;
                end
                S_W: if (master.w_ready) begin
                    pat_q  <= pat_q + DATA_WIDTH'(1);
                    beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                end
                S_B: if (master.b_valid) begin
                    if (!last_burst) begin
                        burst_q <= burst_q + BURST_W'(1);
                        addr_q  <= addr_q + ADDR_WIDTH'(STRIDE);
                    end else begin
                        // Write phase finished: rewind for the read-back
                        burst_q <= '0;
                        addr_q  <= BASE_ADDR;
                        pat_q   <= DATA_WIDTH'(SEED);
                        beat_q  <= '0;
                    end
                end
                S_R: if (master.r_valid) begin
                    pat_q  <= pat_q + DATA_WIDTH'(1);
                    beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                    if (last_beat && !last_burst) begin
                        burst_q <= burst_q + BURST_W'(1);
                        addr_q  <= addr_q + ADDR_WIDTH'(STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error_count = err_q;

    // Write address channel; payload parked at zero while idle
    assign master.aw_id     = '0;
    assign master.aw_addr   = aw_valid_q ? addr_q : '0;
    assign master.aw_len    = 8'(BURST_LEN - 1);
    assign master.aw_size   = 3'(SIZE);
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = '0;
    assign master.aw_prot   = '0;
    assign master.aw_qos    = '0;
    assign master.aw_region = '0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_valid_q;

    // Write data and response channels
    assign master.w_data    = w_valid_q ? pat_q : '0;
    assign master.w_strb    = '1;
    assign master.w_last    = w_valid_q && last_beat;
    assign master.w_user    = '0;
    assign master.w_valid   = w_valid_q;
    assign master.b_ready   = b_ready_q;

    // Read address and data channels
    assign master.ar_id     = '0;
    assign master.ar_addr   = ar_valid_q ? addr_q : '0;
    assign master.ar_len    = 8'(BURST_LEN - 1);
    assign master.ar_size   = 3'(SIZE);
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = '0;
    assign master.ar_prot   = '0;
    assign master.ar_qos    = '0;
    assign master.ar_region = '0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = ar_valid_q;
    assign master.r_ready   = r_ready_q;
endmodule

// File: tb/tb_axi_pattern_master.sv
// Bench for axi_pattern_master: memory-backed slave, transaction-level model, directed runs.
module tb_axi_pattern_master;
    localparam int unsigned BL    = 4;
    localparam int unsigned NB    = 8;
    localparam int unsigned TOTAL = BL * NB;
    localparam logic [63:0] SEED0 = 64'h1000;
    localparam logic [63:0] CTRL0 = 64'({8'h0, 8'd3, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 1'b0});

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, busy, done, start1, busy1, done1;
    logic [15:0] err, err1;

    axi_channel #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(8)) bus0 ();
    axi_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus1 ();

    axi_pattern_master #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(8), .BASE_ADDR(64'h0),
        .BURST_LEN(4), .NUM_BURSTS(8), .SEED(32'h1000)) u0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error_count(err), .master(bus0.master));

    axi_pattern_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .BASE_ADDR(32'h100),
        .BURST_LEN(1), .NUM_BURSTS(1), .SEED(32'h55)) u1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .error_count(err1), .master(bus1.master));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave knobs set by the directed sequence
    int corrupt_k = -1;
    int err_burst = -1;
    bit bp = 1'b0;

    // Slave state
    logic [63:0] mem [logic [63:0]];
    bit          f_aw, f_w, f_b, f_ar, f_r, s_bpend, s_ract;
    logic [63:0] c_awaddr, c_araddr, c_wdata, s_waddr, s_raddr, s_a;
    logic        c_wlast;
    logic [1:0]  s_bresp;
    int          s_wbeat, s_rbeat, s_rk, s_wburst;

    // Memory slave for u0: acts just after negedge on handshakes seen at the previous posedge
    initial begin
        bus0.aw_ready = 0; bus0.w_ready = 0; bus0.ar_ready = 0;
        bus0.b_valid = 0; bus0.b_resp = 0;
        bus0.r_valid = 0; bus0.r_data = 0; bus0.r_resp = 0; bus0.r_last = 0;
        {f_aw, f_w, f_b, f_ar, f_r, s_bpend, s_ract} = '0;
        s_wbeat = 0; s_rbeat = 0; s_rk = 0; s_wburst = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                {f_aw, f_w, f_b, f_ar, f_r, s_bpend, s_ract} = '0;
                s_wbeat = 0; s_rbeat = 0; s_rk = 0; s_wburst = 0;
                bus0.aw_ready = 0; bus0.w_ready = 0; bus0.ar_ready = 0;
                bus0.b_valid = 0; bus0.r_valid = 0;
            end else begin
                if (f_aw) begin
                    s_waddr = c_awaddr; s_wbeat = 0;
                    if (c_awaddr == 64'h0) s_wburst = 0;
                end
                if (f_w) begin
                    mem[s_waddr + 64'(s_wbeat * 8)] = c_wdata;
                    s_wbeat++;
                    if (c_wlast) begin
                        s_bpend = 1;
                        s_bresp = (s_wburst == err_burst) ? 2'b10 : 2'b00;
                        s_wburst++;
                    end
                end
                if (f_b) begin s_bpend = 0; bus0.b_valid = 0; bus0.b_resp = 0; end
                if (f_ar) begin
                    s_raddr = c_araddr; s_rbeat = 0; s_ract = 1;
                    if (c_araddr == 64'h0) s_rk = 0;
                end
                if (f_r) begin
                    bus0.r_valid = 0; s_rbeat++; s_rk++;
                    if (s_rbeat == BL) s_ract = 0;
                end
                bus0.aw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                bus0.w_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                bus0.ar_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (s_bpend && !bus0.b_valid && (!bp || $urandom_range(0, 2) == 0)) begin
                    bus0.b_valid = 1; bus0.b_resp = s_bresp;
                end
                if (s_ract && !bus0.r_valid && (!bp || $urandom_range(0, 2) == 0)) begin
                    s_a = s_raddr + 64'(s_rbeat * 8);
                    bus0.r_valid = 1;
                    bus0.r_data  = (s_rk == corrupt_k) ? 64'h0 : (mem.exists(s_a) ? mem[s_a] : 64'h0);
                    bus0.r_last  = (s_rbeat == BL - 1);
                    bus0.r_resp  = 2'b00;
                end
                f_aw = bus0.aw_valid && bus0.aw_ready; c_awaddr = bus0.aw_addr;
                f_w  = bus0.w_valid && bus0.w_ready;   c_wdata = bus0.w_data; c_wlast = bus0.w_last;
                f_b  = bus0.b_valid && bus0.b_ready;
                f_ar = bus0.ar_valid && bus0.ar_ready; c_araddr = bus0.ar_addr;
                f_r  = bus0.r_valid && bus0.r_ready;
            end
        end
    end

    // Always-responding slave for u1: r_last deliberately wrong, b/r valid held high throughout
    initial begin
        bus1.aw_ready = 1; bus1.w_ready = 1; bus1.ar_ready = 1;
        bus1.b_valid = 1; bus1.b_resp = 0;
        bus1.r_valid = 1; bus1.r_data = 32'h55; bus1.r_resp = 0; bus1.r_last = 0;
    end

    // Transaction-level model state
    bit          in_run, done_exp, wr_pend, rd_pend, aw_pend, w_pend, ar_pend, hit;
    int          awc, wk, arc, rk_m, done_cnt, c1_aw, c1_w, c1_wl, c1_b, c1_ar, c1_r;
    logic [63:0] first_wdata, last_wdata, last_awaddr;

    // Compare process: checks outputs every cycle, then advances the model on observed handshakes
    initial begin
        {in_run, done_exp, wr_pend, rd_pend, aw_pend, w_pend, ar_pend} = '0;
        awc = 0; wk = 0; arc = 0; rk_m = 0; done_cnt = 0;
        c1_aw = 0; c1_w = 0; c1_wl = 0; c1_b = 0; c1_ar = 0; c1_r = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                {in_run, done_exp, wr_pend, rd_pend, aw_pend, w_pend, ar_pend} = '0;
            end else begin
                chk("busy", 64'(busy), 64'(in_run));
                chk("done", 64'(done), 64'(done_exp));
                if (done) done_cnt++;
                if (!in_run) begin
                    chk("idle_handshakes", 64'({bus0.aw_valid, bus0.w_valid, bus0.b_ready,
                        bus0.ar_valid, bus0.r_ready}), 64'h0);
                end else begin
                    chk("b_ready", 64'(bus0.b_ready), 64'(wr_pend));
                    chk("r_ready", 64'(bus0.r_ready), 64'(rd_pend));
                    if (aw_pend) chk("aw_valid_held", 64'(bus0.aw_valid), 64'h1);
                    if (w_pend)  chk("w_valid_held",  64'(bus0.w_valid),  64'h1);
                    if (ar_pend) chk("ar_valid_held", 64'(bus0.ar_valid), 64'h1);
                    if (bus0.aw_valid) begin
                        chk("aw_addr", bus0.aw_addr, 64'(awc) * 64'(BL * 8));
                        chk("aw_ctrl", 64'({bus0.aw_id, bus0.aw_len, bus0.aw_size, bus0.aw_burst,
                            bus0.aw_lock, bus0.aw_cache, bus0.aw_prot, bus0.aw_qos,
                            bus0.aw_region, bus0.aw_user}), CTRL0);
                    end
                    if (bus0.w_valid) begin
                        chk("w_data", bus0.w_data, SEED0 + 64'(wk));
                        chk("w_last", 64'(bus0.w_last), 64'((wk % BL) == BL - 1));
                        chk("w_strb", 64'(bus0.w_strb), 64'hFF);
                    end
                    if (bus0.ar_valid) begin
                        chk("ar_addr", bus0.ar_addr, 64'(arc) * 64'(BL * 8));
                        chk("ar_ctrl", 64'({bus0.ar_id, bus0.ar_len, bus0.ar_size, bus0.ar_burst,
                            bus0.ar_lock, bus0.ar_cache, bus0.ar_prot, bus0.ar_qos,
                            bus0.ar_region, bus0.ar_user}), CTRL0);
                    end
                end
                done_exp = 1'b0;
                if (in_run) begin
                    if (bus0.aw_valid && bus0.aw_ready) begin last_awaddr = bus0.aw_addr; awc++; end
                    if (bus0.w_valid && bus0.w_ready) begin
                        if (wk == 0) first_wdata = bus0.w_data;
                        last_wdata = bus0.w_data;
                        if ((wk % BL) == BL - 1) wr_pend = 1'b1;
                        wk++;
                    end
                    if (bus0.b_valid && bus0.b_ready) wr_pend = 1'b0;
                    if (bus0.ar_valid && bus0.ar_ready) begin rd_pend = 1'b1; arc++; end
                    if (bus0.r_valid && bus0.r_ready) begin
                        rk_m++;
                        if ((rk_m % BL) == 0) rd_pend = 1'b0;
                        if (rk_m == TOTAL) begin in_run = 1'b0; done_exp = 1'b1; end
                    end
                end
                if (start && !busy && !done) begin
                    in_run = 1'b1; awc = 0; wk = 0; arc = 0; rk_m = 0;
                    wr_pend = 1'b0; rd_pend = 1'b0;
                end
                aw_pend = bus0.aw_valid && !bus0.aw_ready;
                w_pend  = bus0.w_valid && !bus0.w_ready;
                ar_pend = bus0.ar_valid && !bus0.ar_ready;

                if (bus1.aw_valid) begin
                    chk("u1_aw_addr", 64'(bus1.aw_addr), 64'h100);
                    chk("u1_aw_len_size", 64'({bus1.aw_len, bus1.aw_size}), 64'({8'd0, 3'd2}));
                end
                if (bus1.w_valid) begin
                    chk("u1_w_data", 64'(bus1.w_data), 64'h55);
                    chk("u1_w_last", 64'(bus1.w_last), 64'h1);
                end
                if (bus1.ar_valid) chk("u1_ar_addr", 64'(bus1.ar_addr), 64'h100);
                if (bus1.aw_valid && bus1.aw_ready) c1_aw++;
                if (bus1.w_valid && bus1.w_ready) begin c1_w++; if (bus1.w_last) c1_wl++; end
                if (bus1.b_valid && bus1.b_ready) c1_b++;
                if (bus1.ar_valid && bus1.ar_ready) c1_ar++;
                if (bus1.r_valid && bus1.r_ready) c1_r++;
                if (start1 && !busy1 && !done1) begin
                    c1_aw = 0; c1_w = 0; c1_wl = 0; c1_b = 0; c1_ar = 0; c1_r = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'h1);
        @(negedge clk);
    endtask

    task automatic run0(input string name, input int ck, input int eb, input bit bpv,
                        input logic [15:0] exp_err);
        int d0;
        corrupt_k = ck; err_burst = eb; bp = bpv;
        d0 = done_cnt;
        pulse_start();
        wait_done(name);
        chk({name, "_error_count"}, 64'(err), 64'(exp_err));
        chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'h1);
        chk({name, "_aw_count"}, 64'(awc), 64'(NB));
        chk({name, "_ar_count"}, 64'(arc), 64'(NB));
    endtask

    // Time limit so the bench always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy_done", 64'({busy, done, busy1, done1}), 64'h0);
        chk("reset_error_count", 64'({err, err1}), 64'h0);
        chk("reset_handshakes", 64'({bus0.aw_valid, bus0.w_valid, bus0.b_ready,
            bus0.ar_valid, bus0.r_ready}), 64'h0);

        // Zero-wait slave, defaults
        run0("zero_wait", -1, -1, 1'b0, 16'd0);
        chk("first_wdata", first_wdata, 64'h1000);
        chk("last_wdata", last_wdata, 64'h101F);
        chk("last_awaddr", last_awaddr, 64'hE0);

        // Random backpressure and response delays
        for (int r = 0; r < 20; r++) run0("backpressure", -1, -1, 1'b1, 16'd0);

        // Corrupted read beat 5 and SLVERR on burst 3
        run0("faults", 5, 3, 1'b0, 16'd2);
        repeat (5) @(negedge clk);
        chk("faults_count_held", 64'(err), 64'd2);

        // Reset in the middle of a write burst
        corrupt_k = -1; err_burst = -1; bp = 1'b0;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (bus0.w_valid && wk == 2) hit = 1'b1;
        end
        chk("mid_w_reached", 64'(hit), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_handshakes", 64'({bus0.aw_valid, bus0.w_valid, bus0.b_ready,
            bus0.ar_valid, bus0.r_ready}), 64'h0);
        chk("mid_rst_busy", 64'({busy, done}), 64'h0);
        run0("after_reset", -1, -1, 1'b0, 16'd0);

        // start coinciding with rst is dropped
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_with_rst_busy", 64'(busy), 64'h0);

        // start while busy is dropped
        d0 = done_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        chk("second_start_busy", 64'(busy), 64'h1);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done("busy_start");
        repeat (20) @(negedge clk);
        chk("busy_start_one_done", 64'(done_cnt - d0), 64'h1);
        chk("busy_start_idle", 64'(busy), 64'h0);
        chk("busy_start_error_count", 64'(err), 64'h0);

        // BURST_LEN=1, NUM_BURSTS=1 instance with wrong r_last
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (done1) hit = 1'b1;
        end
        chk("u1_done_seen", 64'(hit), 64'h1);
        repeat (3) @(negedge clk);
        chk("u1_error_count", 64'(err1), 64'h1);
        chk("u1_counts", 64'({8'(c1_aw), 8'(c1_w), 8'(c1_wl), 8'(c1_b), 8'(c1_ar), 8'(c1_r)}),
            64'h0101_0101_0101);
        chk("u1_idle", 64'({busy1, done1, bus1.b_ready, bus1.r_ready}), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
